// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// Sequences MEM-stage loads and stores onto a valid/addr_ok/data_ok data bus.
// Captures the pipeline request, forms byte strobes and lane-replicated
// store data, holds the pipeline until the bus completes, and returns
// lane-extracted, sign/zero-extended load data.
//
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   req_*                memory request from the MEM stage
//   flush                kill the current MEM instruction
//   stall                freeze pipeline (combinational)
//   misalign             address exception (combinational)
//   resp_valid/rdata     one-cycle completion pulse with extended load data
//   bus_valid..wdata     registered bus request outputs
//   bus_addr_ok/data_ok  bus handshake inputs, bus_rdata raw read word
module mem_access_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        flush,
  output logic        stall,
  output logic        misalign,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        bus_valid,
  output logic        bus_write,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_strobe,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic        kill_reg, kill_next;
  logic        start;

  logic        req_is_word, req_is_half, req_is_byte;
  logic [3:0]  form_strobe;
  logic [31:0] form_wdata;
  logic [1:0]  form_size;

  logic        bus_valid_reg;
  logic        bus_write_reg;
  logic [1:0]  bus_size_reg;
  logic [31:0] bus_addr_reg;
  logic [3:0]  bus_strobe_reg;
  logic [31:0] bus_wdata_reg;
  logic        signed_reg;
  logic        resp_valid_reg;
  logic [31:0] resp_rdata_reg;

  logic [31:0] rdata_shifted;
  logic [7:0]  byte_val;
  logic [15:0] half_val;
  logic [31:0] load_ext;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  always_comb begin
    req_is_word = (req_size == 2'b00);
    req_is_half = (req_size == 2'b01);
    req_is_byte = req_size[1];
    misalign    = req_valid & ((req_is_word & (req_addr[1:0] != 2'b00)) |
                               (req_is_half & req_addr[0]));
    start       = (state_reg == S_IDLE) & req_valid & ~misalign & ~flush;
    form_size   = req_is_word ? 2'd2 : (req_is_half ? 2'd1 : 2'd0);
  end

  // Per-lane strobe and replicated data: each byte lane picks the request
  // byte that lands on it for the given size. Loads drive no strobes or data.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [1:0] LANE     = 2'(gi);
    localparam int         HALF_SRC = 8 * (gi % 2);

    assign form_strobe[gi] = req_write &
                             (req_is_word |
                              (req_is_half & (req_addr[1] == LANE[1])) |
                              (req_is_byte & (req_addr[1:0] == LANE)));

    assign form_wdata[8*gi +: 8] = ~req_write   ? 8'h00 :
                                   req_is_word  ? req_wdata[8*gi +: 8] :
                                   req_is_half  ? req_wdata[HALF_SRC +: 8] :
                                                  req_wdata[7:0];
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
      kill_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      kill_reg  <= kill_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (start) state_next = S_REQ;
      // data_ok before the address is accepted is not a valid completion
      S_REQ:  if (bus_addr_ok) state_next = bus_data_ok ? S_DONE : S_WAIT;
      S_WAIT: if (bus_data_ok) state_next = S_DONE;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase

    // A flushed instruction still finishes its bus transaction; kill only
    // suppresses the response and is dropped on the way back to IDLE.
    kill_next = kill_reg;
    if (((state_reg == S_REQ) || (state_reg == S_WAIT)) && flush)
      kill_next = 1'b1;
    else if (state_reg == S_DONE)
      kill_next = 1'b0;
  end

  // ---------------------------------------------------------------------------
  // FSM: combinational outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    stall = (state_reg == S_REQ) | (state_reg == S_WAIT) | start;
  end

  // ---------------------------------------------------------------------------
  // Load data extraction from the latched address
  // ---------------------------------------------------------------------------
  always_comb begin
    rdata_shifted = bus_rdata >> {bus_addr_reg[1:0], 3'b000};
    byte_val      = rdata_shifted[7:0];
    half_val      = bus_addr_reg[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (bus_size_reg)
      2'd2:    load_ext = bus_rdata;
      2'd1:    load_ext = {{16{signed_reg & half_val[15]}}, half_val};
      default: load_ext = {{24{signed_reg & byte_val[7]}}, byte_val};
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registered bus and response outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_valid_reg  <= 1'b0;
      bus_write_reg  <= 1'b0;
      bus_size_reg   <= 2'd0;
      bus_addr_reg   <= 32'd0;
      bus_strobe_reg <= 4'd0;
      bus_wdata_reg  <= 32'd0;
      signed_reg     <= 1'b0;
      resp_valid_reg <= 1'b0;
      resp_rdata_reg <= 32'd0;
    end else begin
      // bus_valid tracks REQ exactly, so it stays up until addr_ok
      bus_valid_reg <= (state_next == S_REQ);

      // Request fields only change on start, keeping them stable while
      // the bus request is outstanding.
      if (start) begin
        bus_write_reg  <= req_write;
        bus_size_reg   <= form_size;
        bus_addr_reg   <= req_addr;
        bus_strobe_reg <= form_strobe;
        bus_wdata_reg  <= form_wdata;
        signed_reg     <= req_signed & ~req_write;
      end

      // DONE is only entered on data_ok, so bus_rdata is valid here.
      if ((state_next == S_DONE) && !kill_next) begin
        resp_valid_reg <= 1'b1;
        resp_rdata_reg <= bus_write_reg ? 32'd0 : load_ext;
      end else begin
        resp_valid_reg <= 1'b0;
        resp_rdata_reg <= 32'd0;
      end
    end
  end

  assign bus_valid  = bus_valid_reg;
  assign bus_write  = bus_write_reg;
  assign bus_size   = bus_size_reg;
  assign bus_addr   = bus_addr_reg;
  assign bus_strobe = bus_strobe_reg;
  assign bus_wdata  = bus_wdata_reg;
  assign resp_valid = resp_valid_reg;
  assign resp_rdata = resp_rdata_reg;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl: directed scenarios followed by randomized
// transactions, all checked against a behavioural model of the bus protocol.
module tb_mem_access_ctrl;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        flush;
  logic        stall;
  logic        misalign;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        bus_valid;
  logic        bus_write;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr;
  logic [3:0]  bus_strobe;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;

  int checks = 0;
  int errors = 0;

  mem_access_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .flush      (flush),
    .stall      (stall),
    .misalign   (misalign),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .bus_valid  (bus_valid),
    .bus_write  (bus_write),
    .bus_size   (bus_size),
    .bus_addr   (bus_addr),
    .bus_strobe (bus_strobe),
    .bus_wdata  (bus_wdata),
    .bus_addr_ok(bus_addr_ok),
    .bus_data_ok(bus_data_ok),
    .bus_rdata  (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model (plain arithmetic on the request fields)
  // ---------------------------------------------------------------------------
  function automatic logic [3:0] ref_strobe(input logic w, input logic [1:0] sz,
                                            input logic [31:0] a);
    if (!w) return 4'h0;
    if (sz == 2'd0) return 4'hF;
    if (sz == 2'd1) return (a[1] ? 4'hC : 4'h3);
    return 4'(1 << a[1:0]);
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [1:0] sz, input logic [31:0] wd);
    if (sz == 2'd0) return wd;
    if (sz == 2'd1) return 32'(wd[15:0]) * 32'h0001_0001;
    return 32'(wd[7:0]) * 32'h0101_0101;
  endfunction

  function automatic logic [1:0] ref_bsize(input logic [1:0] sz);
    if (sz == 2'd0) return 2'd2;
    if (sz == 2'd1) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [31:0] ref_load(input logic w, input logic [1:0] sz,
                                           input logic sg, input logic [31:0] a,
                                           input logic [31:0] rd);
    logic [31:0] v;
    if (w) return 32'd0;
    if (sz == 2'd0) return rd;
    if (sz == 2'd1) begin
      v = (rd >> (a[1] * 16)) & 32'h0000_FFFF;
      if (sg && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = (rd >> (a[1:0] * 8)) & 32'h0000_00FF;
      if (sg && v[7]) v = v | 32'hFFFF_FF00;
    end
    return v;
  endfunction

  function automatic logic ref_misalign(input logic v, input logic [1:0] sz,
                                        input logic [31:0] a);
    return v && (((sz == 2'd0) && (a % 4 != 0)) || ((sz == 2'd1) && (a % 2 != 0)));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // One complete transaction. a_dly: REQ cycles before addr_ok; d_dly: cycles
  // from addr_ok to data_ok (0 = same cycle). do_flush pulses flush in the
  // first WAIT cycle. noise drives stray data_ok before addr_ok.
  // ---------------------------------------------------------------------------
  task automatic run_txn(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rd, input int a_dly, input int d_dly,
                         input bit do_flush, input bit noise);
    int  c;
    int  ca;
    bit  finished;
    bit  exp_bv;
    req_valid   = 1'b1;
    req_write   = w;
    req_size    = sz;
    req_signed  = sg;
    req_addr    = a;
    req_wdata   = wd;
    flush       = 1'b0;
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    @(negedge clk);
    chk("start_misalign", misalign, 0);
    chk("start_stall", stall, 1);
    chk("start_bus_valid", bus_valid, 0);
    chk("start_resp_valid", resp_valid, 0);
    @(posedge clk); #1;

    c = 1; ca = 0; finished = 1'b0;
    while (!finished) begin
      bus_addr_ok = 1'b0;
      bus_data_ok = 1'b0;
      bus_rdata   = $urandom;
      flush       = 1'b0;
      if (ca == 0) begin
        if (c - 1 == a_dly) begin
          bus_addr_ok = 1'b1;
          ca = c;
          if (d_dly == 0) begin
            bus_data_ok = 1'b1;
            bus_rdata   = rd;
            finished    = 1'b1;
          end
        end else if (noise) begin
          bus_data_ok = 1'($urandom_range(0, 1));
        end
      end else begin
        if (c == ca + d_dly) begin
          bus_data_ok = 1'b1;
          bus_rdata   = rd;
          finished    = 1'b1;
        end
        if (do_flush && c == ca + 1) flush = 1'b1;
      end
      @(negedge clk);
      exp_bv = (ca == 0) || (c == ca);
      chk("busy_stall", stall, 1);
      chk("busy_resp_valid", resp_valid, 0);
      chk("busy_bus_valid", bus_valid, exp_bv);
      if (exp_bv) begin
        chk("bus_addr", bus_addr, a);
        chk("bus_write", bus_write, w);
        chk("bus_size", bus_size, ref_bsize(sz));
        chk("bus_strobe", bus_strobe, ref_strobe(w, sz, a));
        if (w) chk("bus_wdata", bus_wdata, ref_wdata(sz, wd));
      end
      @(posedge clk); #1;
      c++;
    end

    // Response cycle: bus_rdata is scrambled to show the result was captured
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    bus_rdata   = $urandom;
    flush       = 1'b0;
    @(negedge clk);
    chk("resp_valid", resp_valid, !do_flush);
    if (!do_flush) chk("resp_rdata", resp_rdata, ref_load(w, sz, sg, a, rd));
    chk("resp_stall", stall, 0);
    chk("resp_bus_valid", bus_valid, 0);
    $display("txn w=%0d size=%0d signed=%0d addr=%h wdata=%h rdata=%h flush=%0d resp=%h",
             w, sz, sg, a, wd, rd, do_flush, resp_rdata);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic misal_check(input logic [1:0] sz, input logic [31:0] a);
    req_valid = 1'b1;
    req_write = 1'($urandom_range(0, 1));
    req_size  = sz;
    req_addr  = a;
    flush     = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("misalign", misalign, ref_misalign(1'b1, sz, a));
      chk("misalign_stall", stall, 0);
      chk("misalign_bus_valid", bus_valid, 0);
      chk("misalign_resp_valid", resp_valid, 0);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    @(negedge clk);
    chk("misalign_idle", misalign, 0);
    $display("misaligned size=%0d addr=%h", sz, a);
    @(posedge clk); #1;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic        rw;
    logic [1:0]  rsz;
    logic        rsg;
    logic [31:0] ra;
    int          rad;
    int          rdd;
    bit          rfl;

    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_signed = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; flush = 1'b0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_bus_valid", bus_valid, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_bus_strobe", bus_strobe, 0);
    chk("rst_bus_wdata", bus_wdata, 0);
    chk("rst_bus_size", bus_size, 0);
    chk("rst_bus_write", bus_write, 0);
    chk("rst_stall", stall, 0);
    $display("reset state checked");
    @(posedge clk); #1;
    reset = 1'b0;

    // Store byte, minimum latency
    run_txn(1'b1, 2'b10, 1'b0, 32'h0000_1003, 32'h0000_00A5, 32'h0, 0, 0, 1'b0, 1'b0);
    // Signed half load with delayed handshake
    run_txn(1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'h0, 32'h8001_1234, 2, 3, 1'b0, 1'b0);
    // Misaligned word load
    misal_check(2'b00, 32'h0000_3002);
    // Flush in WAIT, then a normal load to show kill was cleared
    run_txn(1'b0, 2'b00, 1'b0, 32'h0000_3100, 32'h0, 32'hDEAD_BEEF, 1, 3, 1'b1, 1'b0);
    run_txn(1'b0, 2'b00, 1'b0, 32'h0000_3104, 32'h0, 32'hCAFE_F00D, 0, 1, 1'b0, 1'b0);
    // Back-to-back lbu then sw
    run_txn(1'b0, 2'b10, 1'b0, 32'h0000_4001, 32'h0, 32'h0000_C300, 0, 0, 1'b0, 1'b0);
    run_txn(1'b1, 2'b00, 1'b0, 32'h0000_4004, 32'h1234_5678, 32'h0, 0, 0, 1'b0, 1'b0);

    // Reset in WAIT
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b00; req_addr = 32'h0000_5000;
    @(posedge clk); #1;
    bus_addr_ok = 1'b1;
    @(posedge clk); #1;
    bus_addr_ok = 1'b0;
    #2;
    reset = 1'b1; req_valid = 1'b0;
    #1;
    chk("rstwait_bus_valid", bus_valid, 0);
    chk("rstwait_stall", stall, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    bus_data_ok = 1'b1; bus_rdata = 32'h1111_2222;
    @(posedge clk); #1;
    bus_data_ok = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rstwait_no_resp", resp_valid, 0);
      chk("rstwait_idle_bus", bus_valid, 0);
      @(posedge clk); #1;
    end
    $display("reset in WAIT checked");

    // Reset in REQ: bus_valid must fall without waiting for a clock edge
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_addr = 32'h0000_6000;
    req_wdata = 32'hA5A5_0F0F;
    @(posedge clk); #1;
    req_valid = 1'b1;
    #2;
    chk("rstreq_pre_bus_valid", bus_valid, 1);
    reset = 1'b1; req_valid = 1'b0;
    #1;
    chk("rstreq_bus_valid", bus_valid, 0);
    chk("rstreq_strobe", bus_strobe, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    $display("reset in REQ checked");

    // Randomized transactions
    for (int n = 0; n < 40; n++) begin
      rsz = 2'($urandom_range(0, 3));
      ra  = $urandom;
      if ($urandom_range(0, 7) == 0 && rsz != 2'b10 && rsz != 2'b11) begin
        if (rsz == 2'd0) ra[1:0] = 2'($urandom_range(1, 3));
        else             ra[0]   = 1'b1;
        misal_check(rsz, ra);
      end else begin
        rw  = 1'($urandom_range(0, 1));
        rsg = 1'($urandom_range(0, 1));
        if (rsz == 2'd0) ra[1:0] = 2'b00;
        if (rsz == 2'd1) ra[0]   = 1'b0;
        rad = $urandom_range(0, 3);
        rdd = $urandom_range(0, 3);
        rfl = (rdd >= 1) && ($urandom_range(0, 5) == 0);
        run_txn(rw, rsz, rsg, ra, $urandom, $urandom, rad, rdd, rfl,
                1'($urandom_range(0, 1)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
